serial_subtract_ctrl: RTL and testbench
=======================================

// Module: serial_subtract_ctrl
// PURPOSE
//   Bit-serial N-bit subtractor controller built around one full_subtract cell.
//   Latches two WIDTH-bit operands on a start request and feeds them LSB-first
//   through the single cell, one bit per clock, carrying the borrow in a flop.
//   Presents the full difference and final borrow with a done pulse.
//   Trades latency for area wherever multi-bit subtraction shares one cell.
// PARAMETERS
//   WIDTH   8   operand/result width in bits (>=2)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      request; sampled only in IDLE or DONE
//   a          in   WIDTH  minuend, latched when start accepted
//   b          in   WIDTH  subtrahend, latched when start accepted
//   borrowIn   in   1      initial borrow, latched when start accepted
//   busy       out  1      high while in SHIFT
//   done       out  1      one-cycle pulse: result valid and updated
//   diff       out  WIDTH  registered result a-b-borrowIn (mod 2^WIDTH)
//   borrowOut  out  1      registered final borrow (1 = unsigned underflow)
// BEHAVIOUR
//   - Reset (async, any time): state=IDLE, counter=0, all internal regs=0;
//     busy=0, done=0, diff=0, borrowOut=0. An in-flight op is discarded, no done.
//   - States: IDLE, SHIFT, DONE (binary encoded; unused codes go to IDLE).
//   - IDLE: start=1 at edge E0 -> latch a,b into shift regs, borrow flop <= borrowIn,
//     counter <= 0, go SHIFT. start=0 -> stay.
//   - SHIFT: each edge applies aSh[0], bSh[0], borrow to full_subtract;
//     diff bit shifts into the result shift reg from the MSB end; borrow flop <= cell
//     borrow; aSh/bSh shift right; counter++.
//     On the edge where counter==WIDTH-1 (edge E_WIDTH): diff <= completed
//     result, borrowOut <= cell borrow, go DONE.
//   - DONE: done=1 for exactly this cycle. start=1 -> accept new op as in IDLE
//     (back-to-back, go SHIFT); else go IDLE.
//   - Latency: start sampled at E0 -> done high for the cycle after E_WIDTH;
//     the next op starts at E_(WIDTH+1) at earliest.
//     Throughput is one op per WIDTH+1 cycles.
//   - start in SHIFT is ignored (no queueing); operand changes after E0 have no effect.
//   - diff/borrowOut change only on the completion edge; they hold the last result
//     through IDLE and through the following operation until its completion.
//   - busy = (state==SHIFT); done = (state==DONE); both purely state-decoded.
//   - Arithmetic: {borrowOut,diff} == {1'b0,a} - b - borrowIn, borrowOut=1 iff
//     a < b+borrowIn (unsigned). Counter is $clog2(WIDTH) bits; no wrap issue since
//     it is reset on every accept.
// TESTING  (WIDTH=8)
//   1 a=8'h05,b=8'h03,bIn=0, start 1 cycle -> busy for 8 cycles, done 9th cycle,
//     diff=8'h02, borrowOut=0.
//   2 a=8'h03,b=8'h05,bIn=0 -> diff=8'hFE, borrowOut=1;
//     a=8'h00,b=8'h00,bIn=1 -> diff=8'hFF, borrowOut=1.
//   3 a=8'hFF,b=8'h00,bIn=0 -> diff=8'hFF,borrowOut=0;
//     a=8'hFF,b=8'hFF,bIn=1 -> diff=8'hFF,borrowOut=1.
//   4 start re-pulsed and a/b changed mid-SHIFT -> ignored; result matches the
//     operands latched at E0, single done pulse.
//   5 reset asserted asynchronously after 3 SHIFT cycles -> outputs 0 immediately,
//     no done; next op 8'h10-8'h01 -> diff=8'h0F, borrowOut=0.
//   6 start held high through DONE -> second op accepted that cycle; two done pulses
//     9 cycles apart; diff holds op1 result until op2 completes.
//   Self-check: every done compared against {1'b0,a}-b-bIn model; 256 random ops.

Source files
------------

// File: rtl/serial_subtract_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full_subtract cell, borrow carried in a flop,
// operands consumed LSB-first, one bit per clock.

module full_subtract (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOut
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             brw;
    logic             cell_d, cell_b;
    logic             accept, finish;

    full_subtract u_cell (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (brw),
        .d    (cell_d),
        .bout (cell_b)
    );

    // New difference bits enter at the MSB end so the first (LSB) bit lands at bit 0.
    assign res_next = {cell_d, res_sh};

    // Handshake: start is a request that is taken on any rising edge where busy is low
    // (IDLE or DONE); while busy is high start is ignored, not queued. done is a
    // one-cycle valid with no back-pressure; diff/borrowOut stay valid until the next done.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            brw       <= 1'b0;
            diff      <= '0;
            borrowOut <= 1'b0;
        end else begin
            if (accept) begin
                a_sh <= a;
                b_sh <= b;
                brw  <= borrowIn;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                brw    <= cell_b;
                res_sh <= res_next[WIDTH-1:1];
                cnt    <= cnt + CW'(1);
            end
            if (finish) begin
                diff      <= res_next;
                borrowOut <= cell_b;
            end
        end
    end
endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Self-checking bench for serial_subtract_ctrl: directed scenarios plus random ops,
// every done checked against an arithmetic model via an expected queue.

module tb_serial_subtract_ctrl;
    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         borrow_in;
    logic         busy, done;
    logic [W-1:0] diff;
    logic         borrow_out;

    logic [W:0] exp_q[$];
    int checks;
    int failures;
    int done_count;

    serial_subtract_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrowIn  (borrow_in),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrowOut (borrow_out)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
        return {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    endfunction

    // scoreboard: pop one expectation per done pulse
    always @(negedge clk) begin
        if (!reset && done) begin
            logic [W:0] e;
            done_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_unexpected_done got=%h", {borrow_out, diff});
            end else begin
                e = exp_q.pop_front();
                if ({borrow_out, diff} !== e) begin
                    failures++;
                    $display("FAIL scoreboard_result got=%h expected=%h", {borrow_out, diff}, e);
                end
            end
        end
    end

    // drivers
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
        @(negedge clk);
        a = ta;
        b = tb_;
        borrow_in = tbin;
        start = 1'b1;
        exp_q.push_back(model(ta, tb_, tbin));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high (or after the bound expires).
    task automatic wait_done(output int busy_n, output bit got);
        busy_n = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin,
                          input string name);
        int  busy_n;
        bit  got;
        issue(ta, tb_, tbin);
        wait_done(busy_n, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s_timeout got=no_done expected=done", name);
        end
        checks++;
        if (busy_n != W) begin
            failures++;
            $display("FAIL %s_busy_cycles got=%0d expected=%0d", name, busy_n, W);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse got=done%b_busy%b expected=done0_busy0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, borrow_out, diff} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h expected=0", {busy, done, borrow_out, diff});
        end
    endtask

    task automatic test_basic();
        run_op(8'h05, 8'h03, 1'b0, "basic_5m3");
        run_op(8'h03, 8'h05, 1'b0, "underflow_3m5");
        run_op(8'h00, 8'h00, 1'b1, "underflow_0m0b");
        run_op(8'hFF, 8'h00, 1'b0, "edge_ffm0");
        run_op(8'hFF, 8'hFF, 1'b1, "edge_ffmffb");
    endtask

    task automatic test_ignore_start();
        int  busy_n;
        bit  got;
        int  dc0;
        dc0 = done_count;
        issue(8'h5A, 8'h33, 1'b1);
        @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        borrow_in = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(busy_n, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL ignore_start_timeout got=no_done expected=done");
        end
        repeat (12) @(negedge clk);
        checks++;
        if (done_count - dc0 != 1) begin
            failures++;
            $display("FAIL ignore_start_done_count got=%0d expected=1", done_count - dc0);
        end
    endtask

    task automatic test_async_reset();
        int dc0;
        issue(8'h77, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        dc0 = done_count;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, borrow_out, diff} !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h expected=0", {busy, done, borrow_out, diff});
        end
        void'(exp_q.pop_back());
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (done_count != dc0) begin
            failures++;
            $display("FAIL async_reset_no_done got=%0d expected=%0d", done_count, dc0);
        end
        run_op(8'h10, 8'h01, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W:0] e1;
        int  busy_n;
        bit  got;
        int  gap;
        e1 = model(8'hC8, 8'h37, 1'b0);
        @(negedge clk);
        a = 8'hC8;
        b = 8'h37;
        borrow_in = 1'b0;
        start = 1'b1;
        exp_q.push_back(e1);
        @(negedge clk);
        a = 8'h20;
        b = 8'h40;
        borrow_in = 1'b1;
        exp_q.push_back(model(8'h20, 8'h40, 1'b1));
        wait_done(busy_n, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL b2b_first_timeout got=no_done expected=done");
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept got=busy%b_done%b expected=busy1_done0", busy, done);
        end
        checks++;
        if ({borrow_out, diff} !== e1) begin
            failures++;
            $display("FAIL b2b_hold got=%h expected=%h", {borrow_out, diff}, e1);
        end
        gap = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            gap++;
        end
        checks++;
        if (!got || gap != W + 1) begin
            failures++;
            $display("FAIL b2b_gap got=%0d expected=%0d", gap, W + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 256; n++) begin
            logic [W-1:0] ra, rb;
            logic rbin;
            ra = W'($urandom_range(0, (1 << W) - 1));
            rb = W'($urandom_range(0, (1 << W) - 1));
            rbin = 1'($urandom_range(0, 1));
            run_op(ra, rb, rbin, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // final report
    initial begin
        checks = 0;
        failures = 0;
        done_count = 0;
        test_reset();
        test_basic();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        test_random();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
